// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the video PLL reset, waits for lock with timeout and
// retry, requires lock to stay stable, then releases the video-domain reset.
// Loss of lock or a reset request re-runs the sequence. Outputs are registered
// and decoded from the next state, so they change together with the state.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 74250,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             req_reset,
   output logic             pll_rst,
   output logic             core_reset,
   output logic             ready,
   output logic [CNT_W-1:0] relock_count,
   output logic [CNT_W-1:0] timeout_count
);

   // The cycle counter only has to reach (largest duration - 1).
   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CYC_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
   localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CYC_W-1:0] cyc_cnt;
   logic [CYC_W-1:0] cyc_cnt_next;
   logic             locked_meta;
   logic             locked_s;
   logic             relock_inc;
   logic             timeout_inc;

   // Two-flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
   always_ff @(posedge refclk) begin
      if (rst) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= pll_locked;
         locked_s    <= locked_meta;
      end
   end

   // Next-state logic; lock loss and timeout outrank a reset request, which outranks progress.
   always_comb begin
      next_state   = state;
      cyc_cnt_next = cyc_cnt + 1'b1;
      relock_inc   = 1'b0;
      timeout_inc  = 1'b0;
      case (state)
         RESET_PLL: begin
            if (cyc_cnt == RST_LAST) next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!locked_s && cyc_cnt == TIMEOUT_LAST) begin
               next_state  = RESET_PLL;
               timeout_inc = 1'b1;
            end else if (req_reset) begin
               next_state = RESET_PLL;
            end else if (locked_s) begin
               next_state = STABILIZE;
            end
         end
         STABILIZE: begin
            if (!locked_s) next_state = WAIT_LOCK;
            else if (req_reset) next_state = RESET_PLL;
            else if (cyc_cnt == STABLE_LAST) next_state = RUN;
         end
         RUN: begin
            cyc_cnt_next = '0;
            if (!locked_s) begin
               next_state = RESET_PLL;
               relock_inc = 1'b1;
            end else if (req_reset) begin
               next_state = RESET_PLL;
            end
         end
         default: next_state = RESET_PLL;
      endcase
      if (next_state != state) cyc_cnt_next = '0;
   end

   // State and cycle-counter register; reset restarts a full PLL reset hold.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state   <= RESET_PLL;
         cyc_cnt <= '0;
      end else begin
         state   <= next_state;
         cyc_cnt <= cyc_cnt_next;
      end
   end

   // Registered outputs decoded from the next state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         ready      <= 1'b0;
      end else begin
         pll_rst    <= (next_state == RESET_PLL);
         core_reset <= (next_state != RUN);
         ready      <= (next_state == RUN);
      end
   end

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge refclk) begin
      if (rst) begin
         relock_count  <= '0;
         timeout_count <= '0;
      end else begin
         if (relock_inc && relock_count != CNT_MAX) relock_count <= relock_count + 1'b1;
         if (timeout_inc && timeout_count != CNT_MAX) timeout_count <= timeout_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: a table for the clean lock-up sequence, hand-written
// corner-case sequences, and randomized traffic checked against a phase/elapsed-time model.
module tb_pll_lock_sequencer;

   localparam int RST_C = 4;
   localparam int TMO   = 20;
   localparam int STB   = 8;
   localparam int CW    = 4;
   localparam int SAT   = (1 << CW) - 1;

   localparam int PH_HOLD   = 0;
   localparam int PH_ACQ    = 1;
   localparam int PH_SETTLE = 2;
   localparam int PH_RUN    = 3;

   logic          refclk = 1'b0;
   logic          rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          req_reset = 1'b0;
   logic          pll_rst;
   logic          core_reset;
   logic          ready;
   logic [CW-1:0] relock_count;
   logic [CW-1:0] timeout_count;

   int total = 0;
   int bad = 0;

   int m_ph = PH_HOLD;
   int m_age = 0;
   int m_relock = 0;
   int m_tmo = 0;
   bit m_sync[$] = '{1'b0, 1'b0};

   typedef struct {
      bit rst;
      bit lk;
      bit rq;
      bit e_prst;
      bit e_core;
      bit e_ready;
      int e_relock;
      int e_tmo;
   } vec_t;

   vec_t vecs[16];

   pll_lock_sequencer #(
      .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB), .CNT_W(CW)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .req_reset(req_reset),
      .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready),
      .relock_count(relock_count), .timeout_count(timeout_count)
   );

   // Free-running reference clock.
   always #5 refclk = ~refclk;

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void model_step(bit r, bit lk, bit rq);
      bit ls;
      int np;
      if (r) begin
         m_ph = PH_HOLD; m_age = 0; m_relock = 0; m_tmo = 0;
         m_sync = '{1'b0, 1'b0};
         return;
      end
      ls = m_sync[0];
      void'(m_sync.pop_front());
      m_sync.push_back(lk);
      np = m_ph;
      case (m_ph)
         PH_HOLD: if (m_age + 1 >= RST_C) np = PH_ACQ;
         PH_ACQ: begin
            if (!ls && m_age + 1 >= TMO) begin
               np = PH_HOLD;
               if (m_tmo < SAT) m_tmo++;
            end else if (rq) np = PH_HOLD;
            else if (ls) np = PH_SETTLE;
         end
         PH_SETTLE: begin
            if (!ls) np = PH_ACQ;
            else if (rq) np = PH_HOLD;
            else if (m_age + 1 >= STB) np = PH_RUN;
         end
         default: begin
            if (!ls) begin
               np = PH_HOLD;
               if (m_relock < SAT) m_relock++;
            end else if (rq) np = PH_HOLD;
         end
      endcase
      m_age = (np != m_ph) ? 0 : m_age + 1;
      m_ph = np;
   endfunction

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(bit r, bit lk, bit rq);
      rst = r;
      pll_locked = lk;
      req_reset = rq;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare everything.
   task automatic cycle(string tag);
      logic [10:0] act;
      logic [10:0] exp;
      @(posedge refclk);
      model_step(rst, pll_locked, req_reset);
      #1;
      act = {pll_rst, core_reset, ready, relock_count, timeout_count};
      exp = {m_ph == PH_HOLD, m_ph != PH_RUN, m_ph == PH_RUN, CW'(m_relock), CW'(m_tmo)};
      check_output({tag, "_model"}, 32'(act), 32'(exp));
   endtask

   task automatic do_reset(bit lk);
      apply_stimulus(1'b1, lk, 1'b0);
      cycle("rst");
      rst = 1'b0;
   endtask

   task automatic wait_for_ready(string tag);
      int n = 0;
      while (!ready && n < 100) begin
         cycle(tag);
         n++;
      end
      check_output({tag, "_ready_reached"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int rises[$];
      int prev;
      int ready_seen;
      int n;
      bit lk;

      // Clean lock-up: pll_rst cycles 0-3, ready and core_reset switch at cycle 13.
      for (int i = 0; i < 16; i++)
         vecs[i] = '{(i == 0), 1'b1, 1'b0, (i <= 3), (i < 13), (i >= 13), 0, 0};
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].lk, vecs[i].rq);
         cycle("t1");
         check_output($sformatf("t1_pll_rst_c%0d", i), 32'(pll_rst), 32'(vecs[i].e_prst));
         check_output($sformatf("t1_core_c%0d", i), 32'(core_reset), 32'(vecs[i].e_core));
         check_output($sformatf("t1_ready_c%0d", i), 32'(ready), 32'(vecs[i].e_ready));
         check_output($sformatf("t1_relock_c%0d", i), 32'(relock_count), 32'(vecs[i].e_relock));
         check_output($sformatf("t1_tmo_c%0d", i), 32'(timeout_count), 32'(vecs[i].e_tmo));
      end

      // Never locks: pll_rst every 24 cycles, timeout_count saturates at 15.
      do_reset(1'b0);
      prev = 1; ready_seen = 0;
      for (int c = 1; c < 24 * 17; c++) begin
         cycle("t2");
         if (pll_rst && !prev) rises.push_back(c);
         prev = int'(pll_rst);
         if (ready) ready_seen = 1;
      end
      check_output("t2_rise_count", 32'(rises.size()), 32'd16);
      for (int k = 1; k < rises.size(); k++)
         check_output($sformatf("t2_period_%0d", k), 32'(rises[k] - rises[k-1]), 32'd24);
      check_output("t2_ready_never", 32'(ready_seen), 32'd0);
      check_output("t2_tmo_sat", 32'(timeout_count), 32'd15);

      // Single-cycle lock drop in RUN: pll_rst rises three cycles later.
      do_reset(1'b1);
      wait_for_ready("t3");
      cycle("t3");
      pll_locked = 1'b0;
      cycle("t3");
      pll_locked = 1'b1;
      check_output("t3_prst_d1", 32'(pll_rst), 32'd0);
      cycle("t3");
      check_output("t3_prst_d2", 32'(pll_rst), 32'd0);
      cycle("t3");
      check_output("t3_prst_d3", 32'(pll_rst), 32'd1);
      check_output("t3_ready_d3", 32'(ready), 32'd0);
      check_output("t3_relock", 32'(relock_count), 32'd1);
      wait_for_ready("t3b");
      check_output("t3_relock_after", 32'(relock_count), 32'd1);

      // Glitch at stabilize count 5: back to WAIT_LOCK, ready delayed to cycle 20.
      do_reset(1'b1);
      for (int c = 1; c <= 8; c++) cycle("t4");
      pll_locked = 1'b0;
      cycle("t4");
      pll_locked = 1'b1;
      for (int c = 10; c <= 19; c++) cycle("t4");
      check_output("t4_ready_c19", 32'(ready), 32'd0);
      cycle("t4");
      check_output("t4_ready_c20", 32'(ready), 32'd1);
      check_output("t4_counts", 32'({relock_count, timeout_count}), 32'd0);

      // Reset request in RUN, then request together with lock loss.
      do_reset(1'b1);
      wait_for_ready("t5");
      req_reset = 1'b1;
      cycle("t5");
      req_reset = 1'b0;
      check_output("t5_req_prst", 32'(pll_rst), 32'd1);
      check_output("t5_req_relock", 32'(relock_count), 32'd0);
      wait_for_ready("t5b");
      pll_locked = 1'b0;
      cycle("t5");
      pll_locked = 1'b1;
      cycle("t5");
      req_reset = 1'b1;
      cycle("t5");
      req_reset = 1'b0;
      check_output("t5_both_prst", 32'(pll_rst), 32'd1);
      wait_for_ready("t5c");
      check_output("t5_relock_final", 32'(relock_count), 32'd1);

      // rst pulse during WAIT_LOCK with three timeouts recorded.
      do_reset(1'b0);
      n = 0;
      while (m_tmo < 3 && n < 200) begin
         cycle("t6");
         n++;
      end
      for (int c = 0; c < 6; c++) cycle("t6");
      check_output("t6_tmo_before", 32'(timeout_count), 32'd3);
      rst = 1'b1;
      cycle("t6");
      rst = 1'b0;
      check_output("t6_rst_out", 32'({pll_rst, core_reset, ready, relock_count, timeout_count}),
                   32'b11000000000);
      for (int c = 1; c <= 3; c++) cycle("t6");
      check_output("t6_prst_c3", 32'(pll_rst), 32'd1);
      cycle("t6");
      check_output("t6_prst_c4", 32'(pll_rst), 32'd0);

      // Randomized traffic against the model.
      do_reset(1'b1);
      lk = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) lk = ~lk;
         apply_stimulus($urandom_range(0, 799) == 0, lk, $urandom_range(0, 59) == 0);
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
